dmem_bus_bridge: RTL and testbench

- Sits between the MEM stage and the external data-memory bus.
- Turns one load/store request per access into a valid/ready command plus a read-response transaction.
- Aligns loads and sign- or zero-extends them; generates byte strobes for stores.
- Stalls the pipeline while an access is in flight and reports misaligned or timed-out accesses.

---
 rtl/dmem_bus_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_bus_bridge.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: bridges one MEM-stage load/store to a valid/ready data-memory
// bus with a separate read-response phase. Loads are lane-selected and extended,
// stores are lane-replicated with byte strobes, the pipeline is stalled while
// the access is in flight, and misaligned or timed-out accesses are flagged.
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   req_valid_m_i .. req_wdata_m_i   MEM-stage request (held while stall_o=1)
//   bus_valid_o, bus_ready_i         command handshake
//   bus_we_o, bus_addr_o             command type and word-aligned address
//   bus_wdata_o, bus_wstrb_o         lane-replicated store data and strobes
//   bus_rvalid_i, bus_rdata_i        read response
//   stall_o                          combinational pipeline freeze
//   done_o, rdata_o                  completion pulse and formatted load data
//   misalign_o, err_o                completion flags (valid with done_o)
module dmem_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid_m_i,
    input  logic        req_we_m_i,
    input  logic [1:0]  req_size_m_i,
    input  logic        req_unsigned_m_i,
    input  logic [31:0] req_addr_m_i,
    input  logic [31:0] req_wdata_m_i,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, CMD, WAIT_R, DONE} state_t;

    localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lane_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             we_q;

    logic             aligned_c;
    logic             timeout_c;
    logic [31:0]      st_data_c;
    logic [3:0]       st_strb_c;

    // Alignment check on the incoming request; size 11 is never legal.
    always_comb begin
        aligned_c = 1'b0;
        case (req_size_m_i)
            2'b00:   aligned_c = 1'b1;
            2'b01:   aligned_c = ~req_addr_m_i[0];
            2'b10:   aligned_c = (req_addr_m_i[1:0] == 2'b00);
            default: aligned_c = 1'b0;
        endcase
    end

    // Store lane replication and strobe generation.
    always_comb begin
        st_data_c = 32'h0;
        st_strb_c = 4'b0000;
        if (req_we_m_i) begin
            case (req_size_m_i)
                2'b00: begin
                    st_data_c = {4{req_wdata_m_i[7:0]}};
                    st_strb_c = 4'b0001 << req_addr_m_i[1:0];
                end
                2'b01: begin
                    st_data_c = {2{req_wdata_m_i[15:0]}};
                    st_strb_c = 4'b0011 << {req_addr_m_i[1], 1'b0};
                end
                default: begin
                    st_data_c = req_wdata_m_i;
                    st_strb_c = 4'b1111;
                end
            endcase
        end
    end

    // Last allowed wait cycle reached with no awaited event.
    assign timeout_c = TO_EN && (cnt == CNT_LAST);

    assign stall_o = (state == CMD) || (state == WAIT_R)
                   || ((state == IDLE) && req_valid_m_i && aligned_c);

    // Select the addressed lane of the read word and extend it.
    function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{lane, 3'b000} +: 8];
        h = rd[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // Access FSM with registered bus and completion outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            bus_valid_o <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'h0;
            bus_wdata_o <= 32'h0;
            bus_wstrb_o <= 4'b0000;
            done_o      <= 1'b0;
            rdata_o     <= 32'h0;
            misalign_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            err_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_m_i) begin
                        if (!aligned_c) begin
                            misalign_o <= 1'b1;
                            done_o     <= 1'b1;
                            rdata_o    <= 32'h0;
                            state      <= DONE;
                        end else begin
                            lane_q      <= req_addr_m_i[1:0];
                            size_q      <= req_size_m_i;
                            uns_q       <= req_unsigned_m_i;
                            we_q        <= req_we_m_i;
                            bus_valid_o <= 1'b1;
                            bus_we_o    <= req_we_m_i;
                            bus_addr_o  <= {req_addr_m_i[31:2], 2'b00};
                            bus_wdata_o <= st_data_c;
                            bus_wstrb_o <= st_strb_c;
                            cnt         <= '0;
                            state       <= CMD;
                        end
                    end
                end
                CMD: begin
                    if (bus_ready_i) begin
                        bus_valid_o <= 1'b0;
                        if (we_q) begin
                            done_o  <= 1'b1;
                            rdata_o <= 32'h0;
                            state   <= DONE;
                        end else begin
                            cnt   <= '0;
                            state <= WAIT_R;
                        end
                    end else if (timeout_c) begin
                        // Abort without a handshake; the bus slave must tolerate this.
                        bus_valid_o <= 1'b0;
                        err_o       <= 1'b1;
                        done_o      <= 1'b1;
                        rdata_o     <= 32'h0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid_i) begin
                        rdata_o <= fmt_load(bus_rdata_i, lane_q, size_q, uns_q);
                        done_o  <= 1'b1;
                        state   <= DONE;
                    end else if (timeout_c) begin
                        err_o   <= 1'b1;
                        done_o  <= 1'b1;
                        rdata_o <= 32'h0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Self-checking bench for dmem_bus_bridge: directed accesses from the test plan
// plus randomized loads/stores with random bus latencies. Expected commands and
// completions are queued by the stimulus and checked by an independent monitor.
module tb_dmem_bus_bridge;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid_m_i, req_we_m_i, req_unsigned_m_i;
    logic [1:0]  req_size_m_i;
    logic [31:0] req_addr_m_i, req_wdata_m_i;
    logic        bus_valid_o, bus_ready_i, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o, done_o, misalign_o, err_o;
    logic [31:0] rdata_o;

    dmem_bus_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid_m_i(req_valid_m_i), .req_we_m_i(req_we_m_i),
        .req_size_m_i(req_size_m_i), .req_unsigned_m_i(req_unsigned_m_i),
        .req_addr_m_i(req_addr_m_i), .req_wdata_m_i(req_wdata_m_i),
        .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
        .misalign_o(misalign_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_load;
        bit          mis;
        bit          err;
        logic [31:0] rdata;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          nvalid;
    } cmd_t;

    done_t done_q[$];
    cmd_t  cmd_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference formatting of a load result from the raw bus word.
    function automatic logic [31:0] exp_load(input logic [31:0] rd, input int a,
                                             input logic [1:0] size, input bit uns);
        logic [31:0] v;
        case (size)
            2'd0: begin
                v = (rd >> (8 * a)) & 32'hFF;
                if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = (rd >> (8 * (a & 2))) & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // Pipeline is frozen while busy, so anything on req_* must be ignored.
    task automatic scramble_req();
        req_valid_m_i    = 1'($urandom % 2);
        req_we_m_i       = 1'($urandom % 2);
        req_size_m_i     = 2'($urandom % 4);
        req_unsigned_m_i = 1'($urandom % 2);
        req_addr_m_i     = $urandom;
        req_wdata_m_i    = $urandom;
    endtask

    // One access; entered and left just after a falling edge with the DUT idle.
    // d_r: CMD cycles before ready (>=TO means never); d_v: WAIT_R cycles before rvalid.
    task automatic do_access(input bit we, input logic [1:0] size, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int d_r, input int d_v, input logic [31:0] rd);
        int    a;
        bit    mis, tmo, hs;
        done_t d;
        cmd_t  c;
        a   = int'(addr % 4);
        mis = (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && a != 0);
        tmo = !mis && (d_r >= int'(TO) || (!we && d_v >= int'(TO)));
        d.is_load = !we;
        d.mis     = mis;
        d.err     = tmo;
        d.rdata   = (mis || tmo || we) ? 32'h0 : exp_load(rd, a, size, uns);
        done_q.push_back(d);
        if (!mis) begin
            c.addr  = addr & 32'hFFFF_FFFC;
            c.we    = we;
            c.wdata = (size == 2'd0) ? (wdata & 32'hFF) * 32'h0101_0101 :
                      (size == 2'd1) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
            c.strb  = !we ? 4'h0 :
                      (size == 2'd0) ? 4'(1 << a) :
                      (size == 2'd1) ? 4'(3 << (a & 2)) : 4'hF;
            c.nvalid = (d_r < int'(TO)) ? d_r + 1 : int'(TO);
            cmd_q.push_back(c);
        end

        req_valid_m_i    = 1'b1;
        req_we_m_i       = we;
        req_size_m_i     = size;
        req_unsigned_m_i = uns;
        req_addr_m_i     = addr;
        req_wdata_m_i    = wdata;
        #1 chk("stall_issue", stall_o, !mis);
        @(negedge clk);
        if (!mis) begin
            hs = 0;
            for (int i = 0; i < int'(TO); i++) begin
                scramble_req();
                bus_ready_i = (i == d_r);
                if (!we) begin
                    // rvalid during CMD, including the handshake cycle, must be ignored.
                    bus_rvalid_i = 1'b1;
                    bus_rdata_i  = $urandom;
                end
                #1 chk("stall_cmd", stall_o, 1);
                @(negedge clk);
                bus_ready_i  = 1'b0;
                bus_rvalid_i = 1'b0;
                if (i == d_r) begin
                    hs = 1;
                    break;
                end
            end
            if (hs && !we) begin
                for (int j = 0; j < int'(TO); j++) begin
                    scramble_req();
                    bus_rvalid_i = (j == d_v);
                    bus_rdata_i  = (j == d_v) ? rd : $urandom;
                    #1 chk("stall_wait", stall_o, 1);
                    @(negedge clk);
                    bus_rvalid_i = 1'b0;
                    if (j == d_v) break;
                end
            end
        end
        req_valid_m_i = 1'b0;
        #1;
        chk("done_timing", done_o, 1);
        chk("stall_done", stall_o, 0);
        @(negedge clk);
    endtask

    // Monitor: compares bus commands and completions against the queued expectations.
    int   vcnt = 0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        cmd_t  c;
        done_t d;
        if (!resetn) begin
            prev_valid = 1'b0;
            vcnt = 0;
        end else begin
            if (bus_valid_o) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", bus_valid_o, 0);
                end else begin
                    c = cmd_q[0];
                    chk("cmd_addr", bus_addr_o, c.addr);
                    chk("cmd_we", bus_we_o, c.we);
                    chk("cmd_strb", bus_wstrb_o, c.strb);
                    if (c.we) chk("cmd_wdata", bus_wdata_o, c.wdata);
                    vcnt++;
                end
            end else if (prev_valid && cmd_q.size() > 0) begin
                c = cmd_q.pop_front();
                chk("cmd_valid_cycles", vcnt, c.nvalid);
                vcnt = 0;
            end
            prev_valid = bus_valid_o;

            if (done_o) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", done_o, 0);
                end else begin
                    d = done_q.pop_front();
                    chk("done_misalign", misalign_o, d.mis);
                    chk("done_err", err_o, d.err);
                    if (d.is_load || d.mis || d.err) chk("done_rdata", rdata_o, d.rdata);
                end
            end else begin
                chk("flags_idle", {misalign_o, err_o}, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        req_valid_m_i = 0; req_we_m_i = 0; req_size_m_i = 0; req_unsigned_m_i = 0;
        req_addr_m_i = 0; req_wdata_m_i = 0;
        bus_ready_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid", bus_valid_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_flags", {misalign_o, err_o}, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed accesses from the test plan.
        do_access(0, 2'd2, 0, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
        do_access(0, 2'd0, 0, 32'h103, 32'h0, 0, 0, 32'h80FF_0011);
        do_access(0, 2'd0, 1, 32'h103, 32'h0, 1, 2, 32'h80FF_0011);
        do_access(0, 2'd1, 0, 32'h102, 32'h0, 0, 1, 32'h8001_7FFF);
        do_access(1, 2'd1, 0, 32'h202, 32'h1234_ABCD, 3, 0, 32'h0);
        do_access(1, 2'd2, 0, 32'h300, 32'hCAFE_F00D, 0, 0, 32'h0);
        do_access(0, 2'd2, 0, 32'h101, 32'h0, 0, 0, 32'h0);
        do_access(0, 2'd3, 0, 32'h100, 32'h0, 0, 0, 32'h0);
        do_access(1, 2'd1, 0, 32'h201, 32'h1, 0, 0, 32'h0);
        do_access(0, 2'd2, 0, 32'h400, 32'h0, int'(TO), 0, 32'h0);
        do_access(1, 2'd0, 0, 32'h401, 32'h77, int'(TO), 0, 32'h0);
        do_access(0, 2'd2, 0, 32'h404, 32'h0, 0, int'(TO), 32'h1111_2222);
        do_access(0, 2'd2, 0, 32'h408, 32'h0, int'(TO) - 1, int'(TO) - 1, 32'h1357_9BDF);

        // Asynchronous reset in WAIT_R abandons the access.
        do_access(0, 2'd2, 0, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
        begin
            cmd_t c;
            c.addr = 32'h100; c.we = 0; c.wdata = 32'h0; c.strb = 4'h0; c.nvalid = 1;
            cmd_q.push_back(c);
        end
        req_valid_m_i = 1; req_we_m_i = 0; req_size_m_i = 2'd2; req_addr_m_i = 32'h100;
        @(negedge clk);
        req_valid_m_i = 0;
        bus_ready_i = 1;
        @(negedge clk);
        bus_ready_i = 0;
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", bus_valid_o, 0);
        chk("arst_we", bus_we_o, 0);
        chk("arst_addr", bus_addr_o, 0);
        chk("arst_wdata", bus_wdata_o, 0);
        chk("arst_strb", bus_wstrb_o, 0);
        chk("arst_stall", stall_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_rdata", rdata_o, 0);
        chk("arst_flags", {misalign_o, err_o}, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        do_access(1, 2'd0, 0, 32'h3, 32'h5A, 0, 0, 32'h0);

        // Randomized accesses with random bus latencies.
        for (int n = 0; n < 300; n++) begin
            bit          we, uns;
            logic [1:0]  size;
            logic [31:0] addr;
            int          d_r, d_v;
            we   = 1'($urandom % 2);
            uns  = 1'($urandom % 2);
            size = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            addr = $urandom;
            if ($urandom % 2 == 0) addr = addr & 32'hFFFF_FFFC;
            d_r  = ($urandom % 6 == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
            d_v  = ($urandom % 6 == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
            do_access(we, size, uns, addr, $urandom, d_r, d_v, $urandom);
        end

        repeat (3) @(negedge clk);
        chk("cmd_queue_empty", cmd_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
